// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming 2x2 max-pool + flatten stage.
package pool_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } pool_state_t;

  // Number of pooled values in one flattened frame.
  function automatic int unsigned pooled_count(input int unsigned channels,
                                               input int unsigned in_h,
                                               input int unsigned in_w);
    return (channels * in_h * in_w) / 4;
  endfunction

  // 8-bit signed maximum.
  function automatic logic signed [DATA_W-1:0] max8(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Horizontal-pair line buffer: synchronous write, registered read.
// The read is issued on the even column of an odd row so the row-above
// pair maximum is waiting in rdata_o when the odd column arrives.
module pool_line_buffer
  import pool_pkg::*;
#(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic                     re_i,
  input  logic [AW-1:0]            raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic signed [DATA_W-1:0] rdata_q;

  // Storage write; contents are overwritten every even row, never cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; holds its value across input gaps.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/maxpool_flatten_stream.sv
// Streaming 2x2/stride-2 signed max-pool feeding a flattened vector to the
// first FC layer. Optional ReLU folding is enabled by defining POOL_RELU_EN.
module maxpool_flatten_stream
  import pool_pkg::*;
#(
  parameter int unsigned CHANNELS = 16,
  parameter int unsigned IN_H     = 10,
  parameter int unsigned IN_W     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid_in,
  output logic signed [DATA_W-1:0] data_out,
  output logic                     data_valid_out,
  output logic                     done
);

  localparam int unsigned TOTAL    = pooled_count(CHANNELS, IN_H, IN_W);
  localparam int unsigned COL_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int unsigned ROW_W    = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned LB_DEPTH = IN_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  pool_state_t              state_q;
  logic [COL_W-1:0]         col_q;
  logic [ROW_W-1:0]         row_q;
  logic [CH_W-1:0]          ch_q;
  logic [CNT_W-1:0]         out_cnt_q;
  logic signed [DATA_W-1:0] h_q;
  logic signed [DATA_W-1:0] data_out_q;
  logic                     data_valid_out_q;
  logic                     done_q;

  logic                     accept_c;
  logic                     col_odd_c;
  logic                     row_odd_c;
  logic [LB_AW-1:0]         lb_addr_c;
  logic signed [DATA_W-1:0] lb_rdata;
  logic signed [DATA_W-1:0] pair_max_c;
  logic signed [DATA_W-1:0] pool_c;
  logic signed [DATA_W-1:0] pool_out_c;

  // Pixels arriving while DONE is shown are dropped.
  assign accept_c   = data_valid_in && (state_q != DONE);
  assign col_odd_c  = col_q[0];
  assign row_odd_c  = row_q[0];
  assign lb_addr_c  = LB_AW'(col_q >> 1);
  assign pair_max_c = max8(h_q, data_in);
  assign pool_c     = max8(lb_rdata, pair_max_c);

`ifdef POOL_RELU_EN
  assign pool_out_c = max8(pool_c, 8'sd0);
`else
  assign pool_out_c = pool_c;
`endif

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (accept_c && col_odd_c && !row_odd_c),
    .waddr_i (lb_addr_c),
    .wdata_i (pair_max_c),
    .re_i    (accept_c && !col_odd_c && row_odd_c),
    .raddr_i (lb_addr_c),
    .rdata_o (lb_rdata)
  );

  // Frame FSM, raster counters, horizontal latch and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      col_q            <= '0;
      row_q            <= '0;
      ch_q             <= '0;
      out_cnt_q        <= '0;
      h_q              <= '0;
      data_out_q       <= '0;
      data_valid_out_q <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      data_valid_out_q <= 1'b0;
      done_q           <= 1'b0;
      case (state_q)
        IDLE, ACTIVE: begin
          if (accept_c) begin
            state_q <= ACTIVE;
            if (!col_odd_c) begin
              h_q <= data_in;
            end
            if (col_q == COL_W'(IN_W - 1)) begin
              col_q <= '0;
              if (row_q == ROW_W'(IN_H - 1)) begin
                row_q <= '0;
                ch_q  <= (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (row_odd_c && col_odd_c) begin
              data_out_q       <= pool_out_c;
              data_valid_out_q <= 1'b1;
              if (out_cnt_q == CNT_W'(TOTAL - 1)) begin
                out_cnt_q <= '0;
                state_q   <= DONE;
              end else begin
                out_cnt_q <= out_cnt_q + 1'b1;
              end
            end
          end
        end
        DONE: begin
          done_q    <= 1'b1;
          col_q     <= '0;
          row_q     <= '0;
          ch_q      <= '0;
          out_cnt_q <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out       = data_out_q;
  assign data_valid_out = data_valid_out_q;
  assign done           = done_q;

endmodule

// File: tb/tb_maxpool_flatten_stream.sv
// Scoreboard bench for maxpool_flatten_stream (default 16x10x10 instance plus
// a 1x2x2 single-window instance). Honours POOL_RELU_EN in its reference model.
module tb_maxpool_flatten_stream;

  localparam int H    = 10;
  localparam int W    = 10;
  localparam int CH   = 16;
  localparam int NPIX = CH * H * W;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic signed [7:0] din, dout, din_s, dout_s;
  logic              vin, vout, done, vin_s, vout_s, done_s;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   p = 0;
  int   frame [NPIX];
  int   rnd [NPIX];
  exp_t exp_q[$];
  int   done_q[$];
  exp_t exp_s[$];
  int   done_sq[$];

  always @(posedge clk) cyc <= cyc + 1;

  maxpool_flatten_stream dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din),
    .data_valid_in  (vin),
    .data_out       (dout),
    .data_valid_out (vout),
    .done           (done)
  );

  maxpool_flatten_stream #(.CHANNELS(1), .IN_H(2), .IN_W(2)) dut_s (
    .clk            (clk),
    .rst            (rst),
    .data_in        (din_s),
    .data_valid_in  (vin_s),
    .data_out       (dout_s),
    .data_valid_out (vout_s),
    .done           (done_s)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int act_fn(input int v);
`ifdef POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Window maximum straight from the stored frame image.
  function automatic int ref_win(input int c, input int pr, input int pc);
    int m = -1000;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (frame[c*H*W + (2*pr+dr)*W + 2*pc + dc] > m)
          m = frame[c*H*W + (2*pr+dr)*W + 2*pc + dc];
    return act_fn(m);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
    end
  endtask

  // Drive one pixel after `gap` idle cycles and queue its expected output.
  task automatic drive(input int v, input int gap);
    int c, r, col, acc;
    exp_t e;
    idle(gap);
    @(negedge clk);
    din = 8'(v);
    vin = 1'b1;
    c   = p / (H*W);
    r   = (p / W) % H;
    col = p % W;
    acc = cyc + 1;
    frame[p] = v;
    if ((r % 2 == 1) && (col % 2 == 1)) begin
      e.val = ref_win(c, r/2, col/2);
      e.cyc = acc;
      exp_q.push_back(e);
      if (p == NPIX - 1) done_q.push_back(acc + 1);
    end
    p = (p + 1) % NPIX;
  endtask

  task automatic run_frame(input int gap_max);
    for (int i = 0; i < NPIX; i++) drive(rnd[i], $urandom_range(0, gap_max));
    idle(3);
  endtask

  // Monitor for the default instance.
  always @(negedge clk) begin
    if (rst) begin
      if (vout) begin
        if (exp_q.size() == 0) check("spurious_valid", int'(vout), 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data_out", int'(dout), e.val);
          check("latency", cyc, e.cyc);
        end
      end
      if (done) begin
        check("done_excl", int'(vout), 0);
        if (done_q.size() == 0) check("spurious_done", int'(done), 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // Monitor for the single-window instance.
  always @(negedge clk) begin
    if (rst) begin
      if (vout_s) begin
        if (exp_s.size() == 0) check("s_spurious_valid", int'(vout_s), 0);
        else begin
          exp_t e;
          e = exp_s.pop_front();
          check("s_data_out", int'(dout_s), e.val);
          check("s_latency", cyc, e.cyc);
        end
      end
      if (done_s) begin
        check("s_done_excl", int'(vout_s), 0);
        if (done_sq.size() == 0) check("s_spurious_done", int'(done_s), 0);
        else check("s_done_cycle", cyc, done_sq.pop_front());
      end
    end
  end

  initial begin
    int   sv [4];
    exp_t e;
    rst = 1'b0; din = '0; vin = 1'b0; din_s = '0; vin_s = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", int'(dout), 0);
    check("rst_valid", int'(vout), 0);
    check("rst_done", int'(done), 0);
    check("rst_s_valid", int'(vout_s), 0);
    rst = 1'b1;
    idle(2);

    // Single window 3,-5,7,1 -> 7.
    sv[0] = 3; sv[1] = -5; sv[2] = 7; sv[3] = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      din_s = 8'(sv[i]);
      vin_s = 1'b1;
      if (i == 3) begin
        e.val = act_fn(7);
        e.cyc = cyc + 1;
        exp_s.push_back(e);
        done_sq.push_back(cyc + 2);
      end
    end
    @(negedge clk);
    vin_s = 1'b0;
    idle(3);

    // All-negative frame.
    for (int i = 0; i < NPIX; i++) rnd[i] = -100;
    run_frame(0);

    // Position-coded frame.
    for (int i = 0; i < NPIX; i++)
      rnd[i] = ((i/(H*W))*100 + ((i/W)%H)*10 + i%W) % 128;
    run_frame(0);

    // Random data, gapless then with random idles.
    for (int i = 0; i < NPIX; i++) rnd[i] = int'($urandom_range(0, 255)) - 128;
    run_frame(0);
    run_frame(5);

    // Extreme windows in the first two pooled positions.
    rnd[0]  = -128; rnd[1]  = 127;  rnd[W]   = 0;    rnd[W+1] = 0;
    rnd[2]  = -128; rnd[3]  = -128; rnd[W+2] = -128; rnd[W+3] = -127;
    run_frame(1);

    // Reset mid-frame after 137 inputs.
    for (int i = 0; i < 137; i++) drive(rnd[i], 0);
    @(negedge clk);
    vin = 1'b0;
    rst = 1'b0;
    p = 0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_valid", int'(vout), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_data_out", int'(dout), 0);
    end
    rst = 1'b1;
    idle(2);
    for (int i = 0; i < NPIX; i++) rnd[i] = int'($urandom_range(0, 255)) - 128;
    run_frame(3);
    idle(5);

    check("outputs_outstanding", exp_q.size(), 0);
    check("done_outstanding", done_q.size(), 0);
    check("s_outputs_outstanding", exp_s.size(), 0);
    check("s_done_outstanding", done_sq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
